mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single memory port between instruction fetch (IF master) and the memory stage (LS master).
- Sits between ifu/mmu and the memory model.
- Accepts one request at a time from one winner and forwards it to memory. Captures the memory response and returns it to the owning master only.
- Non-pipelined: exactly one outstanding transaction.

Parameters:
- DATA_WIDTH, 32, data word width in bits.
- MEM_AW, 32, memory byte-address width.
- MASK_W, DATA_WIDTH/8, byte write-mask width (derived localparam, not overridable).
- REQ_W, MEM_AW+DATA_WIDTH+MASK_W+1, request bus width (derived localparam, not overridable). Packing is {wen, wmask, wdata, addr}, addr in the LSBs.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset (asserted when 0).
- if_req_valid  in  1  IF read request.
- if_req_ready  out  1  IF request accepted this cycle.
- if_req_addr  in  MEM_AW  IF fetch address.
- if_resp_valid  out  1  IF response data valid.
- if_resp_ready  in  1  IF takes response.
- if_resp_data  out  DATA_WIDTH  fetched word.
- ls_req_valid  in  1  LS request.
- ls_req_ready  out  1  LS request accepted this cycle.
- ls_req_bus  in  REQ_W  LS {wen, wmask, wdata, addr}.
- ls_resp_valid  out  1  LS response valid (load data or store ack).
- ls_resp_ready  in  1  LS takes response.
- ls_resp_data  out  DATA_WIDTH  load data; 0 for stores.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_req_bus  out  REQ_W  forwarded request; IF requests sent with wen=0, wmask=0, wdata=0.
- mem_resp_valid  in  1  memory response.
- mem_resp_ready  out  1  arbiter accepts response.
- mem_resp_data  in  DATA_WIDTH  memory read data.
- grant  out  2  one-hot owner, {ls, if}; 00 when idle.

Behaviour:
- FSM states: IDLE, REQ, RESP, RET. Reset (rst=0, async) forces:
  - state=IDLE, grant=00, owner=none;
  - all *_valid and *_ready outputs low;
  - captured request and data regs = 0.
- IDLE:
  - Select a winner from the asserted req_valids. Default policy is fixed priority, LS over IF.
  - The winner's req_ready=1 combinationally in that cycle; the loser's req_ready=0.
  - On the handshake, capture the request into req_reg and the owner into grant, then go to REQ.
  - No valid request: stay in IDLE.
- REQ:
  - mem_req_valid=1 with mem_req_bus=req_reg, held stable.
  - mem_req_ready=1 moves to RESP; otherwise stay (unbounded wait).
- RESP:
  - mem_resp_ready=1.
  - On mem_resp_valid, capture data (forced to 0 if req_reg.wen=1) and go to RET.
- RET:
  - Owner's resp_valid=1 with the captured data; the non-owner's resp_valid stays 0.
  - Owner's resp_ready=1 moves to IDLE and clears grant; otherwise hold.
- Both req_ready outputs are 0 in every state except IDLE. No new request is accepted while a transaction is in flight.
- Minimum latency, all readies high: accept at T, mem_req_valid at T+1, RESP at T+2, resp_valid to master at T+3, IDLE at T+4, next accept at T+4.
- Simultaneous IF and LS requests in IDLE: exactly one accepted. The loser holds valid and is served next.
- Simultaneous mem_req_ready and mem_resp_valid in REQ: mem_resp_valid is ignored. The response is only sampled in RESP.
- Reset mid-transaction: immediate return to IDLE. The in-flight transaction is dropped, and the memory side is reset in the same domain.
- Master req inputs may change freely after acceptance; the arbiter uses only req_reg.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin policy. A last_owner register updates on every accept and resets to IF, so LS wins the first tie after reset. On a tie, the master not granted last wins. A single requester always wins.
- Undefined: fixed priority LS over IF; no last_owner register.
- Both variants have identical FSM timing.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, REQ, RESP, RET);
  - owner one-hot constants OWN_IF=2'b01, OWN_LS=2'b10, OWN_NONE=2'b00;
  - REQ_W/MASK_W width functions and request-field offset localparams.
- Sub-module arb_pick: a combinational selector. Inputs are if_req_valid, ls_req_valid and last_owner; output is the one-hot winner. It holds both policies under the macro.

Test Plan:
- Lone IF read, addr 0x8000_0000, memory returns 0x0000_0413 with zero wait:
  - if_resp_valid at T+3 with data 0x0000_0413;
  - grant=01 from T+1 to T+3;
  - ls_resp_valid never asserted.
- Lone LS store, addr 0x8000_0100, wdata 0xDEADBEEF, wmask 0xF:
  - mem_req_bus carries exactly these fields;
  - ls_resp_valid asserted with data 0.
- IF and LS both valid in the same IDLE cycle, fixed priority:
  - LS accepted first, IF accepted at T+4.
  - With MEM_ARB_RR_EN, repeated ties alternate LS, IF, LS, IF.
- Backpressure: mem_req_ready low 5 cycles, mem_resp_valid delayed 3 cycles, if_resp_ready low 2 cycles:
  - mem_req_bus is stable throughout;
  - each state is held;
  - data is delivered intact and no second request is accepted meanwhile.
- rst driven low asynchronously while in RESP:
  - all valids and readies go 0 and grant=00 before the next clock edge;
  - after release, a new IF request completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and helpers for the memory-port arbiter.
//   - arb_state_e : arbiter FSM states (IDLE, REQ, RESP, RET)
//   - OWN_*       : one-hot owner encodings, bit order {ls, if}
//   - mask_w()/req_w() and the field-offset helpers describe the request bus
//     packing {wen, wmask, wdata, addr}, with addr in the LSBs.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        RET  = 2'd3
    } arb_state_e;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_IF   = 2'b01;
    localparam logic [1:0] OWN_LS   = 2'b10;

    // The address always starts at bit 0; the other fields stack above it.
    localparam int ADDR_LSB = 0;

    function automatic int mask_w(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int req_w(input int mem_aw, input int data_width);
        return mem_aw + data_width + mask_w(data_width) + 1;
    endfunction

    function automatic int wdata_lsb(input int mem_aw);
        return ADDR_LSB + mem_aw;
    endfunction

    function automatic int wmask_lsb(input int mem_aw, input int data_width);
        return wdata_lsb(mem_aw) + data_width;
    endfunction

    function automatic int wen_bit(input int mem_aw, input int data_width);
        return wmask_lsb(mem_aw, data_width) + mask_w(data_width);
    endfunction

endpackage

// File: rtl/arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational winner selection between the IF and LS masters.
//   if_req_valid  in  IF master is requesting
//   ls_req_valid  in  LS master is requesting
//   last_owner    in  one-hot owner of the previous accepted request
//   winner        out one-hot winner {ls, if}; OWN_NONE when nobody requests
// Build option: define MEM_ARB_RR_EN for round-robin on ties; otherwise LS
// always beats IF and last_owner is ignored.
// -----------------------------------------------------------------------------
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic       if_req_valid,
    input  logic       ls_req_valid,
    input  logic [1:0] last_owner,
    output logic [1:0] winner
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        winner = OWN_NONE;
        if (if_req_valid && ls_req_valid) begin
            // Tie: whoever was not served last goes first.
            winner = (last_owner == OWN_LS) ? OWN_IF : OWN_LS;
        end else if (ls_req_valid) begin
            winner = OWN_LS;
        end else if (if_req_valid) begin
            winner = OWN_IF;
        end
    end
`else
    // Fixed priority has no history; keep the port for a uniform interface.
    logic unused_last_owner;
    assign unused_last_owner = ^last_owner;

    always_comb begin
        winner = OWN_NONE;
        if (ls_req_valid) begin
            winner = OWN_LS;
        end else if (if_req_valid) begin
            winner = OWN_IF;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one non-pipelined memory port between instruction fetch (IF) and the
// memory stage (LS). One transaction is in flight at a time:
//   IDLE -> accept winner, REQ -> forward to memory, RESP -> capture data,
//   RET  -> hand data to the owning master.
// Ports:
//   clk, rst                      clock (rising edge), async active-low reset
//   if_req_valid/ready/addr       IF read request
//   if_resp_valid/ready/data      IF read response
//   ls_req_valid/ready/bus        LS request {wen, wmask, wdata, addr}
//   ls_resp_valid/ready/data      LS response (load data, 0 for stores)
//   mem_req_valid/ready/bus       request forwarded to memory
//   mem_resp_valid/ready/data     memory response
//   grant                         one-hot owner {ls, if}, 00 when idle
// Build option: MEM_ARB_RR_EN selects round-robin arbitration on ties
// (default is fixed priority, LS over IF). FSM timing is identical.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int MEM_AW     = 32,
    localparam int MASK_W     = mask_w(DATA_WIDTH),
    localparam int REQ_W      = req_w(MEM_AW, DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [MEM_AW-1:0]     if_req_addr,
    output logic                  if_resp_valid,
    input  logic                  if_resp_ready,
    output logic [DATA_WIDTH-1:0] if_resp_data,

    input  logic                  ls_req_valid,
    output logic                  ls_req_ready,
    input  logic [REQ_W-1:0]      ls_req_bus,
    output logic                  ls_resp_valid,
    input  logic                  ls_resp_ready,
    output logic [DATA_WIDTH-1:0] ls_resp_data,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [REQ_W-1:0]      mem_req_bus,
    input  logic                  mem_resp_valid,
    output logic                  mem_resp_ready,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,

    output logic [1:0]            grant
);

    localparam int WEN_BIT = wen_bit(MEM_AW, DATA_WIDTH);

    arb_state_e            state_q, state_d;
    logic [REQ_W-1:0]      req_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [1:0]            owner_q;
    logic [1:0]            winner;
    logic [1:0]            last_owner;
    logic                  accept;
    logic                  owner_resp_ready;

    arb_pick u_pick (
        .if_req_valid (if_req_valid),
        .ls_req_valid (ls_req_valid),
        .last_owner   (last_owner),
        .winner       (winner)
    );

    // A handshake happens whenever a master is picked in IDLE; the picked
    // master sees ready in the same cycle.
    assign accept = (state_q == IDLE) && (winner != OWN_NONE);

    assign owner_resp_ready = (owner_q == OWN_IF) ? if_resp_ready :
                              (owner_q == OWN_LS) ? ls_resp_ready : 1'b0;

`ifdef MEM_ARB_RR_EN
    logic [1:0] last_owner_q;

    // Starts at IF so the first tie after reset goes to LS.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner_q <= OWN_IF;
        end else if (accept) begin
            last_owner_q <= winner;
        end
    end

    assign last_owner = last_owner_q;
`else
    assign last_owner = OWN_NONE;
`endif

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of block ordering.
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept)           state_d = REQ;
            REQ:  if (mem_req_ready)    state_d = RESP;
            // A response arriving while still in REQ is deliberately ignored.
            RESP: if (mem_resp_valid)   state_d = RET;
            RET:  if (owner_resp_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------- datapath regs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q   <= '0;
            data_q  <= '0;
            owner_q <= OWN_NONE;
        end else begin
            if (accept) begin
                owner_q <= winner;
                // IF fetches are plain reads: wen, wmask and wdata forced to 0.
                req_q   <= (winner == OWN_LS) ? ls_req_bus
                                              : {{(REQ_W-MEM_AW){1'b0}}, if_req_addr};
            end
            if ((state_q == RESP) && mem_resp_valid) begin
                // Stores return an all-zero acknowledge word.
                data_q <= req_q[WEN_BIT] ? '0 : mem_resp_data;
            end
            if ((state_q == RET) && owner_resp_ready) begin
                owner_q <= OWN_NONE;
            end
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        if_req_ready   = 1'b0;
        ls_req_ready   = 1'b0;
        mem_req_valid  = 1'b0;
        mem_resp_ready = 1'b0;
        if_resp_valid  = 1'b0;
        ls_resp_valid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Gate with rst so reset holds every ready low even while the
                // masters keep requesting.
                if_req_ready = rst && accept && (winner == OWN_IF);
                ls_req_ready = rst && accept && (winner == OWN_LS);
            end
            REQ:  mem_req_valid  = 1'b1;
            RESP: mem_resp_ready = 1'b1;
            RET: begin
                if_resp_valid = (owner_q == OWN_IF);
                ls_resp_valid = (owner_q == OWN_LS);
            end
            default: ;
        endcase
    end

    assign mem_req_bus  = req_q;
    assign grant        = owner_q;
    assign if_resp_data = (owner_q == OWN_IF) ? data_q : '0;
    assign ls_resp_data = (owner_q == OWN_LS) ? data_q : '0;

    // MASK_W documents the bus layout; it is folded into REQ_W and WEN_BIT.
    localparam int UNUSED_MASK_W = MASK_W;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with hand-computed expected values.
// Inputs change 2 ns after the rising edge; outputs are checked 1 ns later.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_IF   = 2'b01;
    localparam logic [1:0] OWN_LS   = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_resp_valid, if_resp_ready;
    logic [31:0] if_resp_data;
    logic        ls_req_valid, ls_req_ready;
    logic [68:0] ls_req_bus;
    logic        ls_resp_valid, ls_resp_ready;
    logic [31:0] ls_resp_data;
    logic        mem_req_valid, mem_req_ready;
    logic [68:0] mem_req_bus;
    logic        mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_resp_data;
    logic [1:0]  grant;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_valid   (if_req_valid),
        .if_req_ready   (if_req_ready),
        .if_req_addr    (if_req_addr),
        .if_resp_valid  (if_resp_valid),
        .if_resp_ready  (if_resp_ready),
        .if_resp_data   (if_resp_data),
        .ls_req_valid   (ls_req_valid),
        .ls_req_ready   (ls_req_ready),
        .ls_req_bus     (ls_req_bus),
        .ls_resp_valid  (ls_resp_valid),
        .ls_resp_ready  (ls_resp_ready),
        .ls_resp_data   (ls_resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_bus    (mem_req_bus),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (mem_resp_ready),
        .mem_resp_data  (mem_resp_data),
        .grant          (grant)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #10;
        rst = 1'b1;
    endtask

    // One transaction with memory and masters always ready. The caller has
    // already raised the request valids; drop_* lower them after acceptance.
    task automatic run_txn(input string tag, input logic [1:0] own, input logic [31:0] exp_data,
                           input bit drop_if, input bit drop_ls);
        #1;
        check({tag, "_if_rdy"}, if_req_ready, own == OWN_IF);
        check({tag, "_ls_rdy"}, ls_req_ready, own == OWN_LS);
        tick();
        if (drop_if) if_req_valid = 1'b0;
        if (drop_ls) ls_req_valid = 1'b0;
        #1;
        check({tag, "_t1_grant"}, grant, own);
        check({tag, "_t1_mreq"}, mem_req_valid, 1'b1);
        check({tag, "_t1_rdys"}, {if_req_ready, ls_req_ready}, 2'b00);
        tick();
        #1;
        check({tag, "_t2_mresp_rdy"}, mem_resp_ready, 1'b1);
        check({tag, "_t2_grant"}, grant, own);
        tick();
        #1;
        check({tag, "_t3_resp_v"}, {ls_resp_valid, if_resp_valid}, own);
        check({tag, "_t3_data"}, (own == OWN_IF) ? if_resp_data : ls_resp_data, exp_data);
        tick();
        check({tag, "_t4_grant"}, grant, OWN_NONE);
    endtask

    logic [68:0] exp_bus;

    initial begin
        rst            = 1'b0;
        if_req_valid   = 1'b1;
        ls_req_valid   = 1'b1;
        if_req_addr    = 32'h0;
        ls_req_bus     = '0;
        if_resp_ready  = 1'b1;
        ls_resp_ready  = 1'b1;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0;

        // ------------------------------------------------ reset state
        #2;
        check("rst_grant", grant, OWN_NONE);
        check("rst_req_rdys", {if_req_ready, ls_req_ready}, 2'b00);
        check("rst_mem", {mem_req_valid, mem_resp_ready}, 2'b00);
        check("rst_resp_v", {if_resp_valid, ls_resp_valid}, 2'b00);
        check("rst_bus", mem_req_bus, 69'h0);
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        #10;
        rst = 1'b1;
        tick();

        // ------------------------------------------------ lone IF read
        if_req_valid  = 1'b1;
        if_req_addr   = 32'h8000_0000;
        mem_resp_data = 32'h0000_0413;
        #1;
        check("if_T_rdy", {ls_req_ready, if_req_ready}, 2'b01);
        check("if_T_grant", grant, OWN_NONE);
        tick();
        if_req_valid = 1'b0;
        if_req_addr  = 32'h1234_5678;  // must not leak into the held request
        #1;
        check("if_T1_grant", grant, OWN_IF);
        check("if_T1_mreq", mem_req_valid, 1'b1);
        check("if_T1_bus", mem_req_bus, {1'b0, 4'h0, 32'h0, 32'h8000_0000});
        tick();
        #1;
        check("if_T2_grant", grant, OWN_IF);
        check("if_T2_mresp_rdy", mem_resp_ready, 1'b1);
        check("if_T2_resp_v", if_resp_valid, 1'b0);
        tick();
        #1;
        check("if_T3_grant", grant, OWN_IF);
        check("if_T3_resp", {ls_resp_valid, if_resp_valid}, 2'b01);
        check("if_T3_data", if_resp_data, 32'h0000_0413);
        tick();
        check("if_T4_grant", grant, OWN_NONE);
        check("if_T4_resp", {ls_resp_valid, if_resp_valid}, 2'b00);

        // ------------------------------------------------ lone LS store
        exp_bus       = {1'b1, 4'hF, 32'hDEAD_BEEF, 32'h8000_0100};
        ls_req_valid  = 1'b1;
        ls_req_bus    = exp_bus;
        mem_resp_data = 32'h1234_5678;  // stores must still return 0
        #1;
        check("st_T_rdy", {ls_req_ready, if_req_ready}, 2'b10);
        tick();
        ls_req_valid = 1'b0;
        ls_req_bus   = '0;
        #1;
        check("st_T1_bus", mem_req_bus, exp_bus);
        check("st_T1_grant", grant, OWN_LS);
        tick();
        tick();
        #1;
        check("st_T3_resp", {ls_resp_valid, if_resp_valid}, 2'b10);
        check("st_T3_data", ls_resp_data, 32'h0);
        tick();
        check("st_T4_grant", grant, OWN_NONE);

        // ------------------------------------------------ simultaneous requests
        do_reset();
        tick();
        if_req_valid  = 1'b1;
        if_req_addr   = 32'h8000_0004;
        ls_req_valid  = 1'b1;
        ls_req_bus    = {1'b0, 4'h0, 32'h0, 32'h8000_0200};
        mem_resp_data = 32'h1111_2222;
`ifdef MEM_ARB_RR_EN
        run_txn("rr0", OWN_LS, 32'h1111_2222, 1'b0, 1'b0);
        run_txn("rr1", OWN_IF, 32'h1111_2222, 1'b0, 1'b0);
        run_txn("rr2", OWN_LS, 32'h1111_2222, 1'b0, 1'b0);
        run_txn("rr3", OWN_IF, 32'h1111_2222, 1'b1, 1'b1);
`else
        run_txn("tie_ls", OWN_LS, 32'h1111_2222, 1'b0, 1'b1);
        run_txn("tie_if", OWN_IF, 32'h1111_2222, 1'b1, 1'b1);
`endif

        // ------------------------------------------------ backpressure
        if_req_valid   = 1'b1;
        if_req_addr    = 32'h8000_0040;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        if_resp_ready  = 1'b0;
        mem_resp_data  = 32'hCAFE_F00D;
        tick();
        if_req_valid = 1'b0;
        if_req_addr  = 32'hFFFF_FFFF;
        ls_req_valid = 1'b1;  // must stay unaccepted until we are idle again
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_req_v", mem_req_valid, 1'b1);
            check("bp_req_bus", mem_req_bus, {1'b0, 4'h0, 32'h0, 32'h8000_0040});
            check("bp_req_ls_rdy", ls_req_ready, 1'b0);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_resp_wait", {mem_resp_ready, if_resp_valid}, 2'b10);
            check("bp_resp_ls_rdy", ls_req_ready, 1'b0);
            tick();
        end
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("bp_ret_v", if_resp_valid, 1'b1);
            check("bp_ret_data", if_resp_data, 32'hCAFE_F00D);
            check("bp_ret_grant", grant, OWN_IF);
            check("bp_ret_ls_rdy", ls_req_ready, 1'b0);
            tick();
        end
        ls_req_valid  = 1'b0;
        if_resp_ready = 1'b1;
        tick();
        check("bp_done_grant", grant, OWN_NONE);
        check("bp_done_resp_v", if_resp_valid, 1'b0);

        // ------------------------------------------------ reset while in RESP
        if_req_valid  = 1'b1;
        if_req_addr   = 32'h8000_0060;
        mem_req_ready = 1'b1;
        tick();
        if_req_valid = 1'b0;
        tick();
        #1;
        check("ar_in_resp", mem_resp_ready, 1'b1);
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        rst          = 1'b0;
        #1;
        check("ar_grant", grant, OWN_NONE);
        check("ar_mem", {mem_req_valid, mem_resp_ready}, 2'b00);
        check("ar_req_rdys", {if_req_ready, ls_req_ready}, 2'b00);
        check("ar_resp_v", {if_resp_valid, ls_resp_valid}, 2'b00);
        check("ar_bus", mem_req_bus, 69'h0);
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        #3;
        rst = 1'b1;
        tick();
        if_req_valid   = 1'b1;
        if_req_addr    = 32'h8000_0080;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0BAD_F00D;
        run_txn("ar_after", OWN_IF, 32'h0BAD_F00D, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
